// File: rtl/rom_port_arbiter_pkg.sv
// Shared types for the ROM port arbiter: port indices, per-port slot states,
// latency-pipe entry layout and the address legality check.
package rom_port_arbiter_pkg;

    localparam int   NUM_PORTS = 2;
    localparam logic PORT_IF   = 1'b0;
    localparam logic PORT_LS   = 1'b1;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_PEND = 2'd1,
        SLOT_HOLD = 2'd2
    } slot_state_e;

    typedef struct packed {
        logic valid;
        logic port;
        logic err;
        logic kill;
    } pipe_entry_t;

    localparam int PIPE_ENTRY_W = $bits(pipe_entry_t);

    // Misaligned, or beyond the last ROM word for the given word-address width.
    function automatic logic addr_is_bad(input logic [31:0] addr, input int unsigned aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// One requester's request/response handshake bundle into the ROM arbiter.
interface rom_port_arbiter_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/rom_rsp_slot.sv
// Per-port response slot: IDLE/PEND/HOLD tracking, hold register and the
// bypass mux that presents ROM data in the completion cycle.
module rom_rsp_slot
    import rom_port_arbiter_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_grant,
    input  logic        i_done,
    input  logic        i_done_err,
    input  logic [31:0] i_rom_data,
    input  logic        i_flush,
    input  logic        i_rsp_ready,
    output logic        o_eligible,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err
);

    slot_state_e r_state;
    slot_state_e w_state_next;
    logic [31:0] r_hold_data;
    logic        r_hold_err;
    logic [31:0] w_bypass_data;

    assign w_bypass_data = i_done_err ? 32'd0 : i_rom_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SLOT_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold_data <= 32'd0;
            r_hold_err  <= 1'b0;
        end else if (r_state == SLOT_PEND && i_done) begin
            r_hold_data <= w_bypass_data;
            r_hold_err  <= i_done_err;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_eligible   = 1'b0;
        o_rsp_valid  = 1'b0;
        o_rsp_data   = 32'd0;
        o_rsp_err    = 1'b0;
        case (r_state)
            SLOT_IDLE: begin
                o_eligible = 1'b1;
                if (i_grant) w_state_next = SLOT_PEND;
            end
            SLOT_PEND: begin
                if (i_done) begin
                    o_rsp_valid  = 1'b1;
                    o_rsp_data   = w_bypass_data;
                    o_rsp_err    = i_done_err;
                    w_state_next = i_rsp_ready ? SLOT_IDLE : SLOT_HOLD;
                end
            end
            SLOT_HOLD: begin
                o_rsp_valid = 1'b1;
                o_rsp_data  = r_hold_data;
                o_rsp_err   = r_hold_err;
                o_eligible  = i_rsp_ready;
                if (i_rsp_ready) w_state_next = i_grant ? SLOT_PEND : SLOT_IDLE;
            end
            default: w_state_next = SLOT_IDLE;
        endcase
        // Flush drops whatever is pending or held, but a request accepted in
        // this very cycle survives.
        if (i_flush) w_state_next = i_grant ? SLOT_PEND : SLOT_IDLE;
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Round-robin sharing of a single-ported synchronous ROM between instruction
// fetch and the load unit, with a fixed-latency tag pipe and per-port slots.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_if_flush,
    rom_port_arbiter_if.slave     if_bus,
    rom_port_arbiter_if.slave     ls_bus,
    output logic                  o_rom_en,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [31:0]           i_rom_data
);

    logic [NUM_PORTS-1:0] w_req_valid;
    logic [NUM_PORTS-1:0] w_rsp_ready;
    logic [NUM_PORTS-1:0] w_eligible;
    logic [NUM_PORTS-1:0] w_want;
    logic [NUM_PORTS-1:0] w_grant;
    logic [NUM_PORTS-1:0] w_done;
    logic [NUM_PORTS-1:0] w_rsp_valid;
    logic [NUM_PORTS-1:0] w_rsp_err;
    logic [31:0]          w_rsp_data [NUM_PORTS];

    logic        w_grant_any;
    logic        w_gnt_port;
    logic [31:0] w_gnt_addr;
    logic        w_gnt_err;
    logic        r_last_port;

    pipe_entry_t [READ_LATENCY-1:0] r_pipe;
    pipe_entry_t [READ_LATENCY-1:0] w_pipe_next;
    pipe_entry_t                    w_pipe_out;

    assign w_req_valid = {ls_bus.req_valid, if_bus.req_valid};
    assign w_rsp_ready = {ls_bus.rsp_ready, if_bus.rsp_ready};

    // Nothing is granted while reset is held, so the ROM stays quiet.
    assign w_want      = w_req_valid & w_eligible & {NUM_PORTS{i_rst_n}};
    assign w_grant_any = |w_want;

    always_comb begin
        w_gnt_port = PORT_IF;
        if (w_want == 2'b11) begin
            w_gnt_port = ~r_last_port;
        end else if (w_want[PORT_LS]) begin
            w_gnt_port = PORT_LS;
        end
        w_grant             = '0;
        w_grant[w_gnt_port] = w_grant_any;
    end

    assign w_gnt_addr = (w_gnt_port == PORT_LS) ? ls_bus.req_addr : if_bus.req_addr;
    assign w_gnt_err  = addr_is_bad(w_gnt_addr, ADDR_WIDTH);
    assign o_rom_en   = w_grant_any & ~w_gnt_err;
    assign o_rom_addr = o_rom_en ? w_gnt_addr[ADDR_WIDTH+1:2] : '0;

    assign if_bus.req_ready = w_grant[PORT_IF];
    assign ls_bus.req_ready = w_grant[PORT_LS];

    // Reset value points at LS so the first contested grant goes to IF.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_port <= PORT_LS;
        end else if (w_grant_any) begin
            r_last_port <= w_gnt_port;
        end
    end

    assign w_pipe_next[0] = '{valid: w_grant_any, port: w_gnt_port, err: w_gnt_err, kill: 1'b0};

    // An IF entry advancing during a flush is marked dead; it still walks the
    // pipe so the ROM timing stays aligned, but never completes visibly.
    for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_pipe
        assign w_pipe_next[gi] = '{
            valid: r_pipe[gi-1].valid,
            port:  r_pipe[gi-1].port,
            err:   r_pipe[gi-1].err,
            kill:  r_pipe[gi-1].kill |
                   (i_if_flush & r_pipe[gi-1].valid & (r_pipe[gi-1].port == PORT_IF))
        };
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= w_pipe_next;
        end
    end

    assign w_pipe_out      = r_pipe[READ_LATENCY-1];
    assign w_done[PORT_IF] = w_pipe_out.valid & ~w_pipe_out.kill & (w_pipe_out.port == PORT_IF);
    assign w_done[PORT_LS] = w_pipe_out.valid & ~w_pipe_out.kill & (w_pipe_out.port == PORT_LS);

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slot
        rom_rsp_slot u_slot (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_grant     (w_grant[gi]),
            .i_done      (w_done[gi]),
            .i_done_err  (w_pipe_out.err),
            .i_rom_data  (i_rom_data),
            .i_flush     ((gi == 0) ? i_if_flush : 1'b0),
            .i_rsp_ready (w_rsp_ready[gi]),
            .o_eligible  (w_eligible[gi]),
            .o_rsp_valid (w_rsp_valid[gi]),
            .o_rsp_data  (w_rsp_data[gi]),
            .o_rsp_err   (w_rsp_err[gi])
        );
    end

    assign if_bus.rsp_valid = w_rsp_valid[PORT_IF];
    assign if_bus.rsp_data  = w_rsp_data[PORT_IF];
    assign if_bus.rsp_err   = w_rsp_err[PORT_IF];
    assign ls_bus.rsp_valid = w_rsp_valid[PORT_LS];
    assign ls_bus.rsp_data  = w_rsp_data[PORT_LS];
    assign ls_bus.rsp_err   = w_rsp_err[PORT_LS];

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single-ported instruction ROM (block RAM, 32-bit words, synchronous read) between two requesters: instruction fetch (IF) and load unit (LS, for constant/.rodata loads).
- Handshaked request/response ports; round-robin arbitration; in-order responses with per-port hold registers; IF flush support for branch redirect.
- Sits between the fetch stage, the LSU and the ROM macro.

Parameters:
ADDR_WIDTH, 16, ROM word-address width; ROM covers byte addresses 0 .. 4*2^ADDR_WIDTH-1
READ_LATENCY, 1, ROM cycles from rom_en/rom_addr to valid rom_data; legal 1..3

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req_valid  in  1  IF request valid
if_req_ready  out  1  IF request accepted this cycle when valid&ready
if_req_addr  in  32  IF byte address
if_rsp_valid  out  1  IF response valid
if_rsp_ready  in  1  IF consumer takes response
if_rsp_data  out  32  IF instruction word
if_rsp_err  out  1  IF address misaligned or out of range
if_flush  in  1  discard IF in-flight/held response
ls_req_valid, ls_req_ready, ls_req_addr, ls_rsp_valid, ls_rsp_ready, ls_rsp_data, ls_rsp_err  same as IF set, LS port (no flush)
rom_en  out  1  ROM read enable
rom_addr  out  ADDR_WIDTH  ROM word address
rom_data  in  32  ROM read data

Behaviour:
- Reset (async, rst_n low): all *_rsp_valid=0, *_req_ready=0, rom_en=0, rom_addr=0, rsp data/err=0, pipeline emptied, RR pointer = IF preferred. In-flight reads are dropped, never reported.
- Per-port state: IDLE, PEND (read in flight), HOLD (response presented, not yet taken). One outstanding request per port.
- Port eligible: IDLE, or HOLD with rsp_ready high this cycle (back-to-back). *_req_ready = eligible & granted, combinational.
- Arbitration: if only one eligible port is valid, grant it. If both, grant the port not granted last; pointer updates only on an actual grant. At most one grant per cycle.
- Address check: err if addr[1:0]!=0 or addr[31:ADDR_WIDTH+2]!=0. Legal: rom_en=1, rom_addr=addr[ADDR_WIDTH+1:2] in grant cycle T. Error: rom_en=0, request still flows through the pipeline with err=1, data=0, same latency.
- Pipeline: READ_LATENCY-deep shift of {valid, port, err, kill}; accepts one new grant per cycle.
- Response: in cycle T+READ_LATENCY, rsp_valid=1 and rsp_data=rom_data (bypass). Same cycle, the value is captured into the port hold register; thereafter it is presented from the register until rsp_ready. State becomes HOLD, or IDLE if taken that cycle.
- Fully pipelined: IF and LS grants in consecutive cycles both complete, one per cycle.
- if_flush: kills IF entry in pipeline (kill bit; completes silently, IF state returns IDLE), clears IF HOLD (rsp_valid low next cycle).
  - Flush in the same cycle as an IF accept: the newly accepted request is NOT killed.
  - Flush while if_rsp_valid & if_rsp_ready: the transfer counts; no double effect.
  - if_req_ready is still computed from the pre-flush state that cycle.
- Responses are never dropped while valid&!ready; data/err stay stable until taken.

Decomposition:
- Shared package/header: port index constants (PORT_IF=0, PORT_LS=1), per-port state encoding (IDLE/PEND/HOLD), pipeline-entry field widths.
- One natural sub-module: rom_rsp_slot (per-port state machine + hold register + bypass mux), instantiated twice; arbiter and latency pipe stay in top.

Test Plan:
- IF only, addr 0x0000_0010, READ_LATENCY=1, rsp_ready=1 -> rom_en with rom_addr=4 in T; if_rsp_valid in T+1 with data=mem[4], err=0.
- IF and LS both valid every cycle (IF 0x0,0x4,..; LS 0x100,..), rsp_ready=1 -> grants alternate IF,LS,IF,LS; each port gets one response per two cycles, correct words.
- LS rsp_ready held low 5 cycles -> ls_rsp_valid held, data stable, ls_req_ready=0; IF traffic continues unaffected; release -> LS re-grantable same cycle.
- LS addr 0x0000_0002 and IF addr 0x0004_0000 (ADDR_WIDTH=16) -> rom_en=0 for each; err=1, data=0 after READ_LATENCY.
- READ_LATENCY=2, IF grant in T, if_flush in T+1 -> no if_rsp_valid; new IF request accepted in the flush cycle returns normally.
- rst_n low mid-flight (LS PEND, IF HOLD) -> all rsp_valid=0 immediately; after release, first dual request grants IF.
